// File: rtl/dtlb_mp.sv
// dtlb_mp: N-port fully-associative data TLB, tree-PLRU, invalidate FSM.
// Define DTLB_PERF_EN to build the per-port hit/miss counters.
module dtlb_mp #(
  parameter int NPORTS      = 3,
  parameter int TLB_ENTRIES = 32,
  parameter int NPHYS       = 44,
  parameter int VA_SZ       = 48,
  parameter int ASID_SZ     = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NPORTS-1:0]               rd_enable,
  input  logic [NPORTS*(VA_SZ-12)-1:0]    rd_vaddr,
  input  logic [NPORTS*ASID_SZ-1:0]       rd_asid,
  output logic [NPORTS-1:0]               rd_valid,
  output logic [NPORTS*3-1:0]             rd_pgsz,
  output logic [NPORTS*(NPHYS-12)-1:0]    rd_paddr,
  output logic [NPORTS*6-1:0]             rd_aduwrx,
  input  logic                            wr_entry,
  input  logic [VA_SZ-13:0]               wr_vaddr,
  input  logic [ASID_SZ-1:0]              wr_asid,
  input  logic [NPHYS-13:0]               wr_paddr,
  input  logic [6:0]                      wr_gaduwrx,
  input  logic [2:0]                      wr_pgsz,
  input  logic                            inv_valid,
  output logic                            inv_ready,
  input  logic                            inv_asid_en,
  input  logic                            inv_addr_en,
  input  logic [ASID_SZ-1:0]              inv_asid,
  input  logic [VA_SZ-13:0]               inv_vaddr,
  input  logic                            inv_unified,
  output logic                            inv_done,
  output logic [NPORTS*32-1:0]            perf_hit,
  output logic [NPORTS*32-1:0]            perf_miss
);

  localparam int VW = VA_SZ - 12;
  localparam int PW = NPHYS - 12;
  localparam int NE = TLB_ENTRIES;
  localparam int IW = $clog2(NE);

  typedef enum logic [1:0] {S_IDLE, S_INV, S_DONE} state_e;
  state_e state_q, state_d;

  logic [NE-1:0]      vld_q, vld_d;
  logic [NE-2:0]      plru_q, plru_d;
  logic [VW-1:0]      vpn_q  [NE];
  logic [ASID_SZ-1:0] asid_q [NE];
  logic [PW-1:0]      ppn_q  [NE];
  logic [2:0]         sz_q   [NE];
  logic [6:0]         attr_q [NE];

  logic               ia_en_q, iv_en_q, iuni_q;
  logic [ASID_SZ-1:0] iasid_q;
  logic [VW-1:0]      ivpn_q;

  logic [NPORTS-1:0]      hit;
  logic [IW-1:0]          hidx [NPORTS];
  logic [NPORTS*3-1:0]    pgsz_d;
  logic [NPORTS*PW-1:0]   paddr_d;
  logic [NPORTS*6-1:0]    perm_d;
  logic [NE-1:0]          inv_sel;

  logic          wr_ok, dup, has_inv;
  logic [IW-1:0] wr_idx, dup_idx, inv_idx;

  // VPN bits that take part in the compare for a given page size
  function automatic logic [VW-1:0] cmp_mask(input logic [2:0] sz);
    logic [VW-1:0] m;
    m = '1;
    case (sz)
      3'd1:    m[8:0]  = '0;
      3'd2:    m[9:0]  = '0;
      3'd3:    m[17:0] = '0;
      3'd4:    m[26:0] = '0;
      default: m = '1;
    endcase
    return m;
  endfunction

  function automatic logic [NE-2:0] plru_touch(
    input logic [NE-2:0] t,
    input logic [IW-1:0] e
  );
    logic [NE-2:0] r;
    logic [IW-1:0] n;
    r = t;
    n = '0;
    for (int l = 0; l < IW; l++) begin
      r[n] = ~e[IW-1-l];
      n = (n << 1) + IW'(1) + IW'(e[IW-1-l]);
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] plru_victim(
    input logic [NE-2:0] t
  );
    logic [IW-1:0] v, n;
    v = '0;
    n = '0;
    for (int l = 0; l < IW; l++) begin
      v[IW-1-l] = t[n];
      n = (n << 1) + IW'(1) + IW'(t[n]);
    end
    return v;
  endfunction

  always_comb begin
    hit     = '0;
    pgsz_d  = '0;
    paddr_d = '0;
    perm_d  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      hidx[p] = '0;
      for (int e = NE - 1; e >= 0; e--) begin
        if (rd_enable[p] && state_q == S_IDLE && vld_q[e]
            && (attr_q[e][6]
                || asid_q[e] == rd_asid[p*ASID_SZ +: ASID_SZ])
            && ((vpn_q[e] ^ rd_vaddr[p*VW +: VW])
                & cmp_mask(sz_q[e])) == '0) begin
          hit[p]  = 1'b1;
          hidx[p] = IW'(e);
          pgsz_d[p*3 +: 3]   = pgsz_d[p*3 +: 3] | sz_q[e];
          paddr_d[p*PW +: PW] = paddr_d[p*PW +: PW] | ppn_q[e];
          perm_d[p*6 +: 6]   = perm_d[p*6 +: 6] | attr_q[e][5:0];
        end
      end
    end
  end

  assign wr_ok = wr_entry && (wr_pgsz <= 3'd4);

  always_comb begin
    dup     = 1'b0;
    dup_idx = '0;
    has_inv = 1'b0;
    inv_idx = '0;
    for (int e = NE - 1; e >= 0; e--) begin
      if (vld_q[e] && sz_q[e] == wr_pgsz && asid_q[e] == wr_asid
          && ((vpn_q[e] ^ wr_vaddr) & cmp_mask(wr_pgsz)) == '0) begin
        dup     = 1'b1;
        dup_idx = IW'(e);
      end
      if (!vld_q[e]) begin
        has_inv = 1'b1;
        inv_idx = IW'(e);
      end
    end
    wr_idx = dup ? dup_idx : (has_inv ? inv_idx : plru_victim(plru_q));
  end

  always_comb begin
    inv_sel = '0;
    for (int e = 0; e < NE; e++) begin
      inv_sel[e] = 1'b1;
      if (ia_en_q)
        inv_sel[e] = !attr_q[e][6] && asid_q[e] == iasid_q;
      else if (iv_en_q)
        inv_sel[e] = iuni_q
          || asid_q[e][ASID_SZ-1] == iasid_q[ASID_SZ-1];
      if (iv_en_q && ((vpn_q[e] ^ ivpn_q) & cmp_mask(sz_q[e])) != '0)
        inv_sel[e] = 1'b0;
    end
  end

  // refill lands after the clear so an entry written during INV survives
  always_comb begin
    vld_d = vld_q;
    if (state_q == S_INV) vld_d = vld_q & ~inv_sel;
    if (wr_ok) vld_d[wr_idx] = 1'b1;
    plru_d = plru_q;
    for (int p = 0; p < NPORTS; p++)
      if (hit[p]) plru_d = plru_touch(plru_d, hidx[p]);
    if (wr_ok) plru_d = plru_touch(plru_d, wr_idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q     <= '0;
      plru_q    <= '0;
      rd_valid  <= '0;
      rd_pgsz   <= '0;
      rd_paddr  <= '0;
      rd_aduwrx <= '0;
      ia_en_q   <= 1'b0;
      iv_en_q   <= 1'b0;
      iuni_q    <= 1'b0;
      iasid_q   <= '0;
      ivpn_q    <= '0;
    end else begin
      vld_q     <= vld_d;
      plru_q    <= plru_d;
      rd_valid  <= hit;
      rd_pgsz   <= pgsz_d;
      rd_paddr  <= paddr_d;
      rd_aduwrx <= perm_d;
      if (inv_valid && state_q == S_IDLE) begin
        ia_en_q <= inv_asid_en;
        iv_en_q <= inv_addr_en;
        iuni_q  <= inv_unified;
        iasid_q <= inv_asid;
        ivpn_q  <= inv_vaddr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_ok) begin
      vpn_q[wr_idx]  <= wr_vaddr;
      asid_q[wr_idx] <= wr_asid;
      ppn_q[wr_idx]  <= wr_paddr;
      sz_q[wr_idx]   <= wr_pgsz;
      attr_q[wr_idx] <= wr_gaduwrx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (inv_valid) state_d = S_INV;
      S_INV:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inv_ready = (state_q == S_IDLE);
    inv_done  = (state_q == S_DONE);
  end

`ifdef DTLB_PERF_EN
  logic [31:0] phit_q  [NPORTS];
  logic [31:0] pmiss_q [NPORTS];

  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++) begin
      if (reset) begin
        phit_q[p]  <= '0;
        pmiss_q[p] <= '0;
      end else if (rd_enable[p]) begin
        if (hit[p]) phit_q[p]  <= phit_q[p] + 32'd1;
        else        pmiss_q[p] <= pmiss_q[p] + 32'd1;
      end
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_perf
    assign perf_hit[p*32 +: 32]  = phit_q[p];
    assign perf_miss[p*32 +: 32] = pmiss_q[p];
  end
`else
  assign perf_hit  = '0;
  assign perf_miss = '0;
`endif

endmodule

// File: tb/tb_dtlb_mp.sv
// tb_dtlb_mp: directed bench for dtlb_mp with a lookup scoreboard.
// Expectations for the perf counters follow DTLB_PERF_EN.
module tb_dtlb_mp;
  localparam int NP = 3;
  localparam int VW = 36;
  localparam int PW = 32;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NP-1:0]     rd_enable;
  logic [NP*VW-1:0]  rd_vaddr;
  logic [NP*AW-1:0]  rd_asid;
  logic [NP-1:0]     rd_valid;
  logic [NP*3-1:0]   rd_pgsz;
  logic [NP*PW-1:0]  rd_paddr;
  logic [NP*6-1:0]   rd_aduwrx;
  logic              wr_entry;
  logic [VW-1:0]     wr_vaddr;
  logic [AW-1:0]     wr_asid;
  logic [PW-1:0]     wr_paddr;
  logic [6:0]        wr_gaduwrx;
  logic [2:0]        wr_pgsz;
  logic              inv_valid, inv_ready;
  logic              inv_asid_en, inv_addr_en;
  logic [AW-1:0]     inv_asid;
  logic [VW-1:0]     inv_vaddr;
  logic              inv_unified, inv_done;
  logic [NP*32-1:0]  perf_hit, perf_miss;

  dtlb_mp #(
    .NPORTS(NP), .TLB_ENTRIES(32), .NPHYS(44),
    .VA_SZ(48), .ASID_SZ(16)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_enable(rd_enable), .rd_vaddr(rd_vaddr),
    .rd_asid(rd_asid), .rd_valid(rd_valid),
    .rd_pgsz(rd_pgsz), .rd_paddr(rd_paddr),
    .rd_aduwrx(rd_aduwrx),
    .wr_entry(wr_entry), .wr_vaddr(wr_vaddr),
    .wr_asid(wr_asid), .wr_paddr(wr_paddr),
    .wr_gaduwrx(wr_gaduwrx), .wr_pgsz(wr_pgsz),
    .inv_valid(inv_valid), .inv_ready(inv_ready),
    .inv_asid_en(inv_asid_en), .inv_addr_en(inv_addr_en),
    .inv_asid(inv_asid), .inv_vaddr(inv_vaddr),
    .inv_unified(inv_unified), .inv_done(inv_done),
    .perf_hit(perf_hit), .perf_miss(perf_miss)
  );

  typedef struct {
    int         id;
    int         port;
    logic       v;
    logic [2:0] sz;
    logic [PW-1:0] pa;
    logic [5:0] perm;
  } exp_t;

  exp_t sb[$];
  int ncmp = 0;
  int nfail = 0;
  int nid = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input int p, input logic [VW-1:0] vpn,
                        input logic [AW-1:0] asid, input logic v,
                        input logic [2:0] sz, input logic [PW-1:0] pa,
                        input logic [5:0] perm);
    exp_t x;
    rd_enable[p] = 1'b1;
    rd_vaddr[p*VW +: VW] = vpn;
    rd_asid[p*AW +: AW] = asid;
    x.id = nid;
    x.port = p;
    x.v = v;
    x.sz = v ? sz : 3'd0;
    x.pa = v ? pa : '0;
    x.perm = v ? perm : 6'd0;
    nid++;
    sb.push_back(x);
  endtask

  task automatic miss(input int p, input logic [VW-1:0] vpn,
                      input logic [AW-1:0] asid);
    lookup(p, vpn, asid, 1'b0, 3'd0, '0, 6'd0);
  endtask

  task automatic refill(input logic [VW-1:0] vpn, input logic [AW-1:0] asid,
                        input logic [PW-1:0] pa, input logic g,
                        input logic [5:0] perm, input logic [2:0] sz);
    wr_entry = 1'b1;
    wr_vaddr = vpn;
    wr_asid = asid;
    wr_paddr = pa;
    wr_gaduwrx = {g, perm};
    wr_pgsz = sz;
  endtask

  task automatic tick();
    exp_t x;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk($sformatf("lk%0d.valid", x.id), 128'(rd_valid[x.port]),
          128'(x.v));
      chk($sformatf("lk%0d.pgsz", x.id), 128'(rd_pgsz[x.port*3 +: 3]),
          128'(x.sz));
      chk($sformatf("lk%0d.paddr", x.id), 128'(rd_paddr[x.port*PW +: PW]),
          128'(x.pa));
      chk($sformatf("lk%0d.aduwrx", x.id), 128'(rd_aduwrx[x.port*6 +: 6]),
          128'(x.perm));
    end
    rd_enable = '0;
    wr_entry = 1'b0;
    inv_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int order[$];
    logic [NP*32-1:0] exp_hit, exp_miss;
    reset = 1'b1;
    rd_enable = '0; rd_vaddr = '0; rd_asid = '0;
    wr_entry = 1'b0; wr_vaddr = '0; wr_asid = '0;
    wr_paddr = '0; wr_gaduwrx = '0; wr_pgsz = '0;
    inv_valid = 1'b0; inv_asid_en = 1'b0; inv_addr_en = 1'b0;
    inv_asid = '0; inv_vaddr = '0; inv_unified = 1'b0;
    tick();
    tick();
    chk("rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("rst_rd_paddr", 128'(rd_paddr), 128'(0));
    chk("rst_inv_ready", 128'(inv_ready), 128'(1));
    chk("rst_inv_done", 128'(inv_done), 128'(0));
    chk("rst_perf_hit", 128'(perf_hit), 128'(0));
    reset = 1'b0;
    tick();

    // basic 4k refill then hit on port 1
    refill(36'h12345, 16'd5, 32'hABC, 1'b0, 6'h2F, 3'd0);
    tick();
    lookup(1, 36'h12345, 16'd5, 1'b1, 3'd0, 32'hABC, 6'h2F);
    tick();

    // same-cycle lookup sees pre-write contents
    refill(36'h0ABCD, 16'd7, 32'h0BCD, 1'b0, 6'h15, 3'd0);
    miss(0, 36'h0ABCD, 16'd7);
    tick();
    lookup(0, 36'h0ABCD, 16'd7, 1'b1, 3'd0, 32'h0BCD, 6'h15);
    miss(2, 36'h12345, 16'd6);
    tick();

    // 2M global page
    refill(36'h00200, 16'd5, 32'h777, 1'b1, 6'h3F, 3'd1);
    tick();
    lookup(0, 36'h003FF, 16'd9, 1'b1, 3'd1, 32'h777, 6'h3F);
    miss(2, 36'h00400, 16'd9);
    tick();

    // ASID-filtered invalidate
    inv_valid = 1'b1; inv_asid_en = 1'b1; inv_addr_en = 1'b0;
    inv_asid = 16'd5; inv_unified = 1'b0;
    chk("inv_ready_idle", 128'(inv_ready), 128'(1));
    tick();
    chk("inv_ready_inv", 128'(inv_ready), 128'(0));
    chk("inv_done_inv", 128'(inv_done), 128'(0));
    miss(0, 36'h003FF, 16'd9);
    tick();
    chk("inv_ready_done", 128'(inv_ready), 128'(0));
    chk("inv_done_pulse", 128'(inv_done), 128'(1));
    tick();
    chk("inv_ready_back", 128'(inv_ready), 128'(1));
    chk("inv_done_clr", 128'(inv_done), 128'(0));
    miss(1, 36'h12345, 16'd5);
    lookup(0, 36'h003FF, 16'd9, 1'b1, 3'd1, 32'h777, 6'h3F);
    lookup(2, 36'h0ABCD, 16'd7, 1'b1, 3'd0, 32'h0BCD, 6'h15);
    tick();

    // refill during INV survives the clear
    inv_valid = 1'b1; inv_asid = 16'd7;
    tick();
    refill(36'h55555, 16'd7, 32'h555, 1'b0, 6'h01, 3'd0);
    tick();
    chk("inv2_done", 128'(inv_done), 128'(1));
    tick();
    lookup(0, 36'h55555, 16'd7, 1'b1, 3'd0, 32'h555, 6'h01);
    miss(1, 36'h0ABCD, 16'd7);
    tick();

    // address-filtered unified invalidate hits the 2M page
    inv_valid = 1'b1; inv_asid_en = 1'b0; inv_addr_en = 1'b1;
    inv_vaddr = 36'h00300; inv_unified = 1'b1;
    tick();
    tick();
    tick();
    miss(0, 36'h003FF, 16'd9);
    lookup(1, 36'h55555, 16'd7, 1'b1, 3'd0, 32'h555, 6'h01);
    tick();

    // reset while INV: back to idle with no done pulse
    inv_valid = 1'b1; inv_addr_en = 1'b0; inv_unified = 1'b0;
    tick();
    chk("rinv_busy", 128'(inv_ready), 128'(0));
    reset = 1'b1;
    tick();
    chk("rinv_ready", 128'(inv_ready), 128'(1));
    chk("rinv_done", 128'(inv_done), 128'(0));
    reset = 1'b0;
    tick();
    chk("rinv_done2", 128'(inv_done), 128'(0));
    miss(0, 36'h55555, 16'd7);
    tick();

    // illegal page size is dropped
    refill(36'h99999, 16'd1, 32'h999, 1'b0, 6'h3F, 3'd5);
    tick();
    miss(0, 36'h99999, 16'd1);
    tick();

    // fill all entries, then hit 0..30 so the PLRU points at 31
    for (int i = 0; i < 32; i++) begin
      refill(36'h1000 + 36'(i), 16'd1, 32'h2000 + 32'(i), 1'b0, 6'h3F, 3'd0);
      tick();
    end
    order = {30, 28, 29, 24, 25, 26, 27};
    for (int i = 16; i < 24; i++) order.push_back(i);
    for (int i = 0; i < 16; i++) order.push_back(i);
    for (int k = 0; k < order.size(); k++) begin
      lookup(k % NP, 36'h1000 + 36'(order[k]), 16'd1, 1'b1, 3'd0,
             32'h2000 + 32'(order[k]), 6'h3F);
      tick();
    end
    refill(36'h9000, 16'd1, 32'h9999, 1'b0, 6'h3F, 3'd0);
    tick();
    miss(0, 36'h101F, 16'd1);
    lookup(1, 36'h1000, 16'd1, 1'b1, 3'd0, 32'h2000, 6'h3F);
    lookup(2, 36'h101E, 16'd1, 1'b1, 3'd0, 32'h201E, 6'h3F);
    tick();
    lookup(0, 36'h9000, 16'd1, 1'b1, 3'd0, 32'h9999, 6'h3F);
    tick();
    refill(36'h1005, 16'd1, 32'h3333, 1'b0, 6'h3F, 3'd0);
    tick();
    lookup(0, 36'h1005, 16'd1, 1'b1, 3'd0, 32'h3333, 6'h3F);
    lookup(1, 36'h1006, 16'd1, 1'b1, 3'd0, 32'h2006, 6'h3F);
    tick();

    // perf counters: 3 hits + 2 misses on port 2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    refill(36'h4242, 16'd3, 32'h42, 1'b0, 6'h3F, 3'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      lookup(2, 36'h4242, 16'd3, 1'b1, 3'd0, 32'h42, 6'h3F);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      miss(2, 36'h4243, 16'd3);
      tick();
    end
`ifdef DTLB_PERF_EN
    exp_hit = {32'd3, 32'd0, 32'd0};
    exp_miss = {32'd2, 32'd0, 32'd0};
`else
    exp_hit = '0;
    exp_miss = '0;
`endif
    chk("perf_hit", 128'(perf_hit), 128'(exp_hit));
    chk("perf_miss", 128'(perf_miss), 128'(exp_miss));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
